free_list: RTL
==============

# free_list

Circular FIFO of free physical register tags that sits directly upstream of dispatch on the `flist_disp` path. It hands dispatch the next free tag each cycle. It reclaims tags released by ROB commit. On a branch mispredict it rolls its head pointer back to the value captured in the branch checkpoint. Tag 0 is permanently bound to x0 and never enters the list.

## Interface
Parameters:
- PHYS_REGS, 64, total physical registers; tag width PHYS_BITS = $clog2(PHYS_REGS).
- FL_DEPTH, PHYS_REGS-32, list capacity (power of two); FL_BITS = $clog2(FL_DEPTH).

Ports:
- clk  in  1  clock; single clock domain, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- dequeue  in  1  dispatch consumes `phys_reg` this cycle.
- phys_reg  out  PHYS_BITS  tag at head (combinational read).
- empty  out  1  no free tag available.
- cur_head  out  FL_BITS+1  head pointer including wrap bit; dispatch checkpoints it.
- flush  in  1  mispredict recovery.
- ckpt_head  in  FL_BITS+1  head value to restore on flush.
- enqueue  in  1  ROB commit frees a tag.
- free_preg  in  PHYS_BITS  tag being freed.
- count  out  FL_BITS+1  number of free tags (tail − head, modulo 2^(FL_BITS+1)).

## Operation
- Storage: FL_DEPTH × PHYS_BITS array `mem`, head and tail pointers each FL_BITS+1 wide, where the MSB is the wrap bit.
- Array index = pointer[FL_BITS-1:0].
- empty = (head == tail).
- full = wrap bits differ and indices are equal.
- Reset (async):
  - mem[i] = 32+i.
  - head = 0.
  - tail = {1'b1, FL_BITS'0}, i.e. the list starts full.
- Dequeue: if dequeue && !empty && !flush, head += 1. If dequeue arrives while empty, it is ignored and nothing changes.
- Enqueue: if enqueue && free_preg != 0, then mem[tail] = free_preg and tail += 1. A freed tag of 0 is dropped silently.
- Enqueue while full is illegal. Simulation assertion fires; tail does not advance.
- Flush: head = ckpt_head. Dequeue in the same cycle is ignored. Enqueue in the same cycle still completes, and tail is never touched by flush.
  - Tags allocated after the checkpoint therefore become free again.
  - Committed frees are preserved.
- Simultaneous dequeue and enqueue (not empty): both pointers advance and count is unchanged.
- Pointer arithmetic wraps naturally modulo 2^(FL_BITS+1).
- phys_reg = mem[head index] at all times. Its value is don't-care when empty, unless the bypass feature below is compiled in.
- No state machine beyond the two pointers. The block has no stall outputs other than empty.

## Timing
- Read latency 0: phys_reg and empty reflect the current head and tail combinationally.
- Dequeue, enqueue and flush take effect on the next rising edge. A tag freed in cycle N is visible at phys_reg no earlier than cycle N+1, and only if it sits at the head.
- Output values after reset: phys_reg = 32, empty = 0, cur_head = 0, count = FL_DEPTH.
- Reset asserted mid-operation discards all in-flight frees and reloads the initial contents immediately, without waiting for a clock.
- cur_head is the pre-update head in the cycle of dequeue. Dispatch adds 1 itself when checkpointing a linking branch that allocates.

## Configuration
- FLIST_BYPASS_EN defined:
  - When the list is empty and enqueue is valid with free_preg != 0, empty deasserts and phys_reg = free_preg combinationally.
  - If dequeue is also asserted, the tag is consumed directly. mem[tail] is written, and head and tail both advance.
  - This path is not taken during flush.
- FLIST_BYPASS_EN undefined: empty depends only on the pointers. A freed tag is usable the cycle after commit.

## Test plan
- Reset with PHYS_REGS=64:
  - Required: phys_reg=32, count=32, empty=0.
  - Then assert dequeue for 32 cycles: phys_reg steps 32..63, then empty=1 and count=0.
- Drain fully, then enqueue tags 40, 0, 35 on consecutive cycles:
  - Tag 0 is dropped, count=2, and phys_reg=40 followed by 35 after one dequeue.
  - Dequeue on empty changes no state.
- Start from reset and dequeue 5 times so cur_head=5. Then flush with ckpt_head=2 while simultaneously enqueuing 50:
  - head=2, phys_reg=34, and tail has advanced by one with mem[old tail]=50.
- Wrap-around:
  - Drain fully, enqueue 32 tags, dequeue 32 times. head and tail wrap back to wrap bit 0 and the list reports empty.
  - Enqueue while full triggers the assertion and leaves count=32.
- Simultaneous dequeue and enqueue at count=10 for 20 cycles: count stays 10 and the FIFO ordering of tags is preserved.
- With FLIST_BYPASS_EN and an empty list, enqueue 45 with dequeue in the same cycle:
  - phys_reg=45 and empty=0 combinationally.
  - The next cycle count=0 and empty=1.
  - Without the macro, empty stays 1 in that cycle.

Source files
------------

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags feeding dispatch.
//
// Hands dispatch the tag at the head each cycle. Tags released by ROB commit
// are appended at the tail. On a branch mispredict the head is restored from
// the branch checkpoint, so tags allocated after the branch become free again.
// Tag 0 is bound to x0 and is never accepted into the list.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   dequeue     dispatch consumes phys_reg this cycle
//   phys_reg    tag at head (combinational)
//   empty       no free tag available
//   cur_head    head pointer with wrap bit (pre-update), for checkpointing
//   flush       mispredict recovery: head <= ckpt_head
//   ckpt_head   head value to restore on flush
//   enqueue     ROB commit frees free_preg
//   free_preg   tag being freed (0 is dropped)
//   count       number of free tags (tail - head)
//
// Build option:
//   FLIST_BYPASS_EN  when the list is empty, a tag being freed this cycle is
//                    presented on phys_reg at once and may be consumed in the
//                    same cycle.
module free_list #(
    parameter int PHYS_REGS = 64,
    parameter int FL_DEPTH  = PHYS_REGS - 32,
    localparam int PHYS_BITS = $clog2(PHYS_REGS),
    localparam int FL_BITS   = $clog2(FL_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dequeue,
    output logic [PHYS_BITS-1:0] phys_reg,
    output logic                 empty,
    output logic [FL_BITS:0]     cur_head,
    input  logic                 flush,
    input  logic [FL_BITS:0]     ckpt_head,
    input  logic                 enqueue,
    input  logic [PHYS_BITS-1:0] free_preg,
    output logic [FL_BITS:0]     count
);

    logic [PHYS_BITS-1:0] mem_q [FL_DEPTH];
    logic [FL_BITS:0]     head_q, head_d;
    logic [FL_BITS:0]     tail_q, tail_d;
    logic                 ptr_empty, full;
    logic                 enq_ok, deq_ok, byp;

    assign ptr_empty = (head_q == tail_q);
    // Same index with differing wrap bits means the tail has lapped the head.
    assign full      = (head_q[FL_BITS] != tail_q[FL_BITS]) &&
                       (head_q[FL_BITS-1:0] == tail_q[FL_BITS-1:0]);
    assign enq_ok    = enqueue && (free_preg != '0) && !full;

`ifdef FLIST_BYPASS_EN
    // Only reachable when empty, so enq_ok is implied (an empty list is never full).
    assign byp = ptr_empty && enqueue && (free_preg != '0) && !flush;
`else
    assign byp = 1'b0;
`endif

    assign empty    = ptr_empty && !byp;
    assign phys_reg = byp ? free_preg : mem_q[head_q[FL_BITS-1:0]];
    assign cur_head = head_q;
    assign count    = tail_q - head_q;
    assign deq_ok   = dequeue && !empty && !flush;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        // Flush wins over dequeue; tail is owned solely by commit.
        if (flush)
            head_d = ckpt_head;
        else if (deq_ok)
            head_d = head_q + 1'b1;
        if (enq_ok)
            tail_d = tail_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= {1'b1, {FL_BITS{1'b0}}};
            for (int i = 0; i < FL_DEPTH; i++)
                mem_q[i] <= PHYS_BITS'(PHYS_REGS - FL_DEPTH + i);
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            if (enq_ok)
                mem_q[tail_q[FL_BITS-1:0]] <= free_preg;
        end
    end

`ifndef SYNTHESIS
    // Commit must never free more tags than the list can hold.
    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(enqueue && (free_preg != '0) && full))
                else $error("free_list: enqueue while full, tag %0d dropped", free_preg);
    end
`endif

endmodule
